// File: rtl/mbist_march_ctrl_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
package mbist_march_ctrl_pkg;

   typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
   typedef enum logic {OP_R, OP_W} op_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   localparam march_elem_e LAST_ELEM = M5;

   // Address order of each element: 1 = descending.
   function automatic logic elem_down(input march_elem_e e);
      return (e == M3) || (e == M4);
   endfunction

   function automatic logic [1:0] elem_nops(input march_elem_e e);
      return ((e == M0) || (e == M5)) ? 2'd1 : 2'd2;
   endfunction

   function automatic op_e elem_op(input march_elem_e e, input logic ph);
      case (e)
         M0:      return OP_W;
         M5:      return OP_R;
         default: return ph ? OP_W : OP_R;
      endcase
   endfunction

   // 1 selects the inverted background for operation ph of element e.
   function automatic logic elem_inv(input march_elem_e e, input logic ph);
      case (e)
         M1, M3:  return ph;
         M2, M4:  return ~ph;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port RAM port as seen from the controller (master) and the RAM (slave).
interface mbist_march_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
);
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport master (output ram_we, ram_addr, ram_din, input ram_dout);
   modport slave  (input ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/mbist_march_ctrl_addr_gen.sv
// Up/down march address counter; load picks the direction and the start address.
module mbist_march_ctrl_addr_gen #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              down_in,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   logic down;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         down <= 1'b0;
      end else if (load) begin
         down <= down_in;
         addr <= down_in ? '1 : '0;
      end else if (step) begin
         addr <= down ? addr - ONE : addr + ONE;
      end
   end

   assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: sequences the RAM through the march, compares reads
// and muxes the RAM port between functional logic and the BIST engine.
module mbist_march_ctrl
   import mbist_march_ctrl_pkg::*;
#(
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] BG     = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               func_we,
   input  logic [ADDR_W-1:0]  func_addr,
   input  logic [DATA_W-1:0]  func_din,
   mbist_march_ctrl_if.master ram,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [ADDR_W-1:0]  fail_addr,
   output logic [2:0]         fail_elem,
   output logic [DATA_W-1:0]  fail_exp,
   output logic [DATA_W-1:0]  fail_act,
   output logic [7:0]         fail_cnt
);
   state_e            state, state_nx;
   logic              start_acc;
   march_elem_e       elem, elem_nx;
   logic              ph, exhausted;
   logic              issue, op_last, elem_end;
   op_e               cur_op;
   logic              gen_load, gen_down, gen_step, gen_last;
   logic [ADDR_W-1:0] gen_addr;
   logic              we_p0, rd_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [DATA_W-1:0] din_p0;
   march_elem_e       elem_p0;
   logic              vld_p1, miscmp;
   logic [ADDR_W-1:0] addr_p1;
   march_elem_e       elem_p1;
   logic [DATA_W-1:0] exp_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_RUN;
         S_RUN:          if (exhausted) state_nx = S_DRAIN;
         S_DRAIN:        state_nx = S_DONE;
         default:        state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      start_acc = 1'b0;
      case (state)
         S_IDLE:         start_acc = start;
         S_RUN, S_DRAIN: busy = 1'b1;
         S_DONE: begin
            done      = 1'b1;
            start_acc = start;
         end
         default: ;
      endcase
   end

   assign issue    = (state == S_RUN) && !exhausted;
   assign op_last  = ({1'b0, ph} + 2'd1) == elem_nops(elem);
   assign elem_end = op_last && gen_last;
   assign elem_nx  = march_elem_e'(elem + 3'd1);
   assign cur_op   = elem_op(elem, ph);
   assign gen_load = start_acc || (issue && elem_end && (elem != LAST_ELEM));
   assign gen_down = start_acc ? elem_down(M0) : elem_down(elem_nx);
   assign gen_step = issue && op_last && !gen_last;

   mbist_march_ctrl_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (gen_load),
      .down_in (gen_down),
      .step    (gen_step),
      .addr    (gen_addr),
      .last    (gen_last)
   );

   // Sequencer: element / operation position; exhausted marks the last op issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem      <= M0;
         ph        <= 1'b0;
         exhausted <= 1'b0;
      end else if (start_acc) begin
         elem      <= M0;
         ph        <= 1'b0;
         exhausted <= 1'b0;
      end else if (issue) begin
         if (!op_last) begin
            ph <= 1'b1;
         end else begin
            ph <= 1'b0;
            if (gen_last) begin
               if (elem == LAST_ELEM) exhausted <= 1'b1;
               else                   elem      <= elem_nx;
            end
         end
      end
   end

   // Stage p0: BIST drive registers; reads carry the expected pattern in din_p0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_p0   <= 1'b0;
         rd_p0   <= 1'b0;
         addr_p0 <= '0;
         din_p0  <= '0;
         elem_p0 <= M0;
      end else if (issue) begin
         we_p0   <= (cur_op == OP_W);
         rd_p0   <= (cur_op == OP_R);
         addr_p0 <= gen_addr;
         din_p0  <= elem_inv(elem, ph) ? ~BG : BG;
         elem_p0 <= elem;
      end else begin
         we_p0 <= 1'b0;
         rd_p0 <= 1'b0;
      end
   end

   // Stage p1: read context aligned with the RAM's registered output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= rd_p0;
   end

   always_ff @(posedge clk) begin
      addr_p1 <= addr_p0;
      elem_p1 <= elem_p0;
      exp_p1  <= din_p0;
   end

   assign miscmp = vld_p1 && (ram.ram_dout != exp_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fail      <= 1'b0;
         fail_cnt  <= '0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else if (start_acc) begin
         fail      <= 1'b0;
         fail_cnt  <= '0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else if (miscmp) begin
         fail <= 1'b1;
         if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
         if (!fail) begin
            fail_addr <= addr_p1;
            fail_elem <= elem_p1;
            fail_exp  <= exp_p1;
            fail_act  <= ram.ram_dout;
         end
      end
   end

   always_comb begin
      ram.ram_we   = busy ? we_p0   : func_we;
      ram.ram_addr = busy ? addr_p0 : func_addr;
      ram.ram_din  = busy ? din_p0  : func_din;
   end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: a string-driven March C- model predicts
// every RAM operation and the final verdict against a fault-injecting RAM model.
module tb_mbist_march_ctrl;
   localparam int AW       = 6;
   localparam int DW       = 8;
   localparam int DEPTH    = 1 << AW;
   localparam int NOPS     = 10 * DEPTH;
   localparam int BUSY_LEN = NOPS + 2;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   typedef struct packed {
      logic          fail;
      logic [7:0]    cnt;
      logic [AW-1:0] addr;
      logic [2:0]    elem;
      logic [DW-1:0] exp;
      logic [DW-1:0] act;
   } res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start1 = 1'b0, start2 = 1'b0, fwe1 = 1'b0, fwe2 = 1'b0;
   logic [AW-1:0] faddr1 = '0, faddr2 = '0;
   logic [DW-1:0] fdin1 = '0, fdin2 = '0;
   logic          busy1, done1, fail1, busy2, done2, fail2;
   logic [AW-1:0] faila1, faila2;
   logic [2:0]    faile1, faile2;
   logic [DW-1:0] failx1, failx2, failv1, failv2;
   logic [7:0]    cnt1, cnt2;

   mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) rif1 ();
   mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) rif2 ();

   mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(8'h00)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .func_we(fwe1), .func_addr(faddr1),
      .func_din(fdin1), .ram(rif1), .busy(busy1), .done(done1), .fail(fail1),
      .fail_addr(faila1), .fail_elem(faile1), .fail_exp(failx1), .fail_act(failv1),
      .fail_cnt(cnt1));

   mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(8'h55)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .func_we(fwe2), .func_addr(faddr2),
      .func_din(fdin2), .ram(rif2), .busy(busy2), .done(done2), .fail(fail2),
      .fail_addr(faila2), .fail_elem(faile2), .fail_exp(failx2), .fail_act(failv2),
      .fail_cnt(cnt2));

   // Fault model: mode 1 = one bit stuck at flt_val at flt_addr, mode 2 = mask flipped everywhere.
   int            flt_mode = 0;
   logic [AW-1:0] flt_addr = '0;
   logic [DW-1:0] flt_mask = '0;
   logic          flt_val  = 1'b0;

   function automatic logic [DW-1:0] flt(input int mode, input logic [AW-1:0] fa,
                                         input logic [DW-1:0] mask, input logic v,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (mode == 1 && a == fa) return v ? (d | mask) : (d & ~mask);
      if (mode == 2) return d ^ mask;
      return d;
   endfunction

   logic [DW-1:0] mem1 [DEPTH];
   logic [DW-1:0] mem2 [DEPTH];

   always @(posedge clk) begin
      rif1.ram_dout <= flt(flt_mode, flt_addr, flt_mask, flt_val, rif1.ram_addr, mem1[rif1.ram_addr]);
      if (rif1.ram_we) mem1[rif1.ram_addr] <= rif1.ram_din;
   end

   always @(posedge clk) begin
      rif2.ram_dout <= mem2[rif2.ram_addr];
      if (rif2.ram_we) mem2[rif2.ram_addr] <= rif2.ram_din;
   end

   logic          sel = 1'b0;
   logic          m_busy, m_done, m_fail, m_we;
   logic [AW-1:0] m_addr, m_faila;
   logic [DW-1:0] m_din, m_failx, m_failv;
   logic [2:0]    m_faile;
   logic [7:0]    m_cnt;

   always_comb begin
      m_busy = sel ? busy2 : busy1;
      m_done = sel ? done2 : done1;
      m_fail = sel ? fail2 : fail1;
      m_cnt  = sel ? cnt2  : cnt1;
      m_faila = sel ? faila2 : faila1;
      m_faile = sel ? faile2 : faile1;
      m_failx = sel ? failx2 : failx1;
      m_failv = sel ? failv2 : failv1;
      m_we   = sel ? rif2.ram_we   : rif1.ram_we;
      m_addr = sel ? rif2.ram_addr : rif1.ram_addr;
      m_din  = sel ? rif2.ram_din  : rif1.ram_din;
   end

   int   tests = 0;
   int   fails = 0;
   op_t  op_q [$];
   res_t res_q [$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endfunction

   // Reference: walk the March C- notation on an array memory seen through the fault model.
   task automatic predict(input logic [DW-1:0] bg);
      string         march [6] = '{"W0", "R0W1", "R1W0", "R0W1", "R1W0", "R0"};
      logic [DW-1:0] m [DEPTH];
      res_t          r;
      r = '0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            int    a;
            string s;
            a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
            s = march[e];
            for (int j = 0; j < s.len(); j += 2) begin
               logic [DW-1:0] pat, got;
               pat = (s[j+1] == "1") ? ~bg : bg;
               if (s[j] == "W") begin
                  m[a] = pat;
                  op_q.push_back(op_t'({1'b1, AW'(a), pat}));
               end else begin
                  op_q.push_back(op_t'({1'b0, AW'(a), pat}));
                  got = flt(flt_mode, flt_addr, flt_mask, flt_val, AW'(a), m[a]);
                  if (got != pat) begin
                     if (!r.fail) begin
                        r.addr = AW'(a);
                        r.elem = 3'(e);
                        r.exp  = pat;
                        r.act  = got;
                     end
                     r.fail = 1'b1;
                     if (r.cnt != 8'hFF) r.cnt = r.cnt + 8'd1;
                  end
               end
            end
         end
      end
      res_q.push_back(r);
   endtask

   // Monitor: slot 0 and the drain slot must be idle, slots 1..NOPS carry the march ops.
   int   mon_n    = 0;
   logic mon_prev = 1'b0;
   always @(negedge clk) begin
      op_t  e;
      res_t r;
      if (m_busy === 1'b1) begin
         mon_n = mon_prev ? mon_n + 1 : 0;
         if (mon_n == 0 || mon_n == BUSY_LEN - 1) begin
            chk("idle_slot_we", 32'(m_we), 32'd0);
         end else if (mon_n <= NOPS) begin
            if (op_q.size() == 0) chk("op_q_size", 32'(op_q.size()), 32'd1);
            else begin
               e = op_q.pop_front();
               chk($sformatf("ram_op[%0d]", mon_n - 1),
                   {17'd0, m_we, m_addr, m_we ? m_din : 8'h00},
                   {17'd0, e.we, e.addr, e.we ? e.data : 8'h00});
            end
         end else if (mon_n == BUSY_LEN) begin
            chk("busy_len_overrun", 32'(mon_n), 32'(BUSY_LEN - 1));
         end
      end else if (mon_prev) begin
         if (rst_n !== 1'b1) begin
            op_q.delete();
            if (res_q.size() > 0) r = res_q.pop_front();
         end else begin
            chk("busy_len", 32'(mon_n + 1), 32'(BUSY_LEN));
            chk("done_at_end", 32'(m_done), 32'd1);
            chk("ops_left", 32'(op_q.size()), 32'd0);
            if (res_q.size() == 0) chk("res_q_size", 32'(res_q.size()), 32'd1);
            else begin
               r = res_q.pop_front();
               chk("fail", 32'(m_fail), 32'(r.fail));
               chk("fail_cnt", 32'(m_cnt), 32'(r.cnt));
               if (r.fail) begin
                  chk("fail_addr", 32'(m_faila), 32'(r.addr));
                  chk("fail_elem", 32'(m_faile), 32'(r.elem));
                  chk("fail_exp", 32'(m_failx), 32'(r.exp));
                  chk("fail_act", 32'(m_failv), 32'(r.act));
               end
            end
         end
      end
      mon_prev = (m_busy === 1'b1);
   end

   task automatic pulse_start();
      @(negedge clk);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      chk("busy_after_start", 32'(m_busy), 32'd1);
      chk("start_clears_done", 32'(m_done), 32'd0);
      chk("start_clears_fail", 32'(m_fail), 32'd0);
      chk("start_clears_cnt", 32'(m_cnt), 32'd0);
      chk("start_clears_addr", 32'(m_faila), 32'd0);
   endtask

   task automatic poke_start();
      @(negedge clk);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
      chk("busy_kept_on_restart", 32'(m_busy), 32'd1);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (m_done !== 1'b1 && k < 3 * BUSY_LEN) begin
         @(negedge clk);
         k++;
      end
      fwe1 = 1'b0;
      chk("done_within_bound", 32'(m_done), 32'd1);
      @(negedge clk);
   endtask

   task automatic run_test(input logic [DW-1:0] bg, input bit restart_mid, input bit func_noise);
      predict(bg);
      pulse_start();
      if (func_noise) begin
         fwe1   = 1'b1;
         faddr1 = AW'($urandom);
         fdin1  = DW'($urandom);
      end
      if (restart_mid) begin
         repeat (98) @(negedge clk);
         poke_start();
      end
      wait_done();
   endtask

   task automatic write_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      fwe1 = 1'b1; faddr1 = a; fdin1 = d;
      @(negedge clk);
      fwe1 = 1'b0;
      @(negedge clk);
      chk($sformatf("passthrough[%0d]", a), 32'(rif1.ram_dout), 32'(d));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fwe1 = 1'b1; faddr1 = 6'd9; fdin1 = 8'h3C;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_fail", 32'(fail1), 32'd0);
      chk("rst_cnt", 32'(cnt1), 32'd0);
      chk("rst_fail_fields", {faila1, faile1, failx1, failv1}, 32'd0);
      chk("rst_mux", {rif1.ram_we, rif1.ram_addr, rif1.ram_din}, {1'b1, 6'd9, 8'h3C});
      fwe1 = 1'b0;
      rst_n = 1'b1;

      write_read(6'd5, 8'hA5);
      for (int i = 0; i < 3; i++) write_read(AW'($urandom), DW'($urandom));

      flt_mode = 0;
      run_test(8'h00, 1'b1, 1'b1);

      flt_mode = 1; flt_addr = 6'd10; flt_mask = 8'h08; flt_val = 1'b1;
      run_test(8'h00, 1'b0, 1'b1);
      chk("stuck_bit3_addr10_cnt", 32'(cnt1), 32'd3);

      flt_mode = 0;
      run_test(8'h00, 1'b0, 1'b0);

      flt_mode = 2; flt_mask = DW'($urandom_range(1, 255));
      run_test(8'h00, 1'b0, 1'b0);
      chk("saturated_cnt", 32'(cnt1), 32'd255);

      for (int i = 0; i < 3; i++) begin
         flt_mode = $urandom_range(0, 2);
         flt_addr = AW'($urandom);
         flt_val  = 1'($urandom);
         flt_mask = (flt_mode == 1) ? DW'(1 << $urandom_range(0, DW - 1)) : DW'($urandom_range(1, 255));
         run_test(8'h00, 1'b0, 1'b1);
      end

      flt_mode = 1; flt_addr = 6'd10; flt_mask = 8'h08; flt_val = 1'b1;
      predict(8'h00);
      pulse_start();
      repeat (298) @(negedge clk);
      chk("fail_before_abort", 32'(fail1), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_done", 32'(done1), 32'd0);
      chk("abort_fail", 32'(fail1), 32'd0);
      fwe1 = 1'b1; faddr1 = 6'd33; fdin1 = 8'h5A;
      #1;
      chk("abort_mux", {rif1.ram_we, rif1.ram_addr, rif1.ram_din}, {1'b1, 6'd33, 8'h5A});
      fwe1 = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      flt_mode = 0;
      run_test(8'h00, 1'b0, 1'b0);

      sel = 1'b1;
      run_test(8'h55, 1'b0, 1'b0);
      sel = 1'b0;

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
